// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Decode-stage read-after-write hazard detector for the 5-stage WISC
//   pipeline, which has no forwarding paths. The destination specifiers of
//   in-flight writers (EX, MEM, WB) are carried in a small shift pipeline
//   and compared against the ID-stage source specifiers. On a match the
//   block raises o_stall, which holds the PC and IF/ID register and turns
//   the instruction entering EX into a bubble. A saturating counter keeps
//   track of how many cycles were lost to stalls.
//
// Parameters:
//   DEPTH      number of tracked in-flight slots; slot 0 = EX, DEPTH-1 = WB
//   WB_BYPASS  1: register file writes before it reads, so WB never hazards
//   CNT_W      width of the stall-cycle counter
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_id_valid     ID holds a real instruction
//   i_id_rs        source specifier A
//   i_id_rs_en     instruction reads rs
//   i_id_rt        source specifier B
//   i_id_rt_en     instruction reads rt
//   i_id_rd        destination specifier
//   i_id_wr_en     instruction writes rd
//   i_flush        ID instruction is squashed (taken branch/jump)
//   i_cnt_clr      clear the stall counter
//   o_stall        hold PC and IF/ID, insert a bubble into EX
//   o_hazard_slot  one-hot youngest slot matching a source, 0 when no stall
//   o_stall_cnt    saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [2:0]       i_id_rs,
  input  logic             i_id_rs_en,
  input  logic [2:0]       i_id_rt,
  input  logic             i_id_rt_en,
  input  logic [2:0]       i_id_rd,
  input  logic             i_id_wr_en,
  input  logic             i_flush,
  input  logic             i_cnt_clr,
  output logic             o_stall,
  output logic [DEPTH-1:0] o_hazard_slot,
  output logic [CNT_W-1:0] o_stall_cnt
);

  // Highest slot index that can still cause a hazard. With write-before-read
  // in the register file the WB slot has already landed its result, so it is
  // left out of the comparison. May be negative for degenerate DEPTH values,
  // in which case nothing is ever checked.
  localparam int LAST = DEPTH - 1 - WB_BYPASS;

  // Constant mask of the slots that take part in source matching.
  function automatic logic [DEPTH-1:0] build_check_mask();
    logic [DEPTH-1:0] m;
    m = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k <= LAST) begin
        m[k] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0] CHECK_MASK = build_check_mask();

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Scoreboard state: one valid bit and one destination specifier per slot.
  logic [DEPTH-1:0]      r_slot_v;
  logic [DEPTH-1:0][2:0] r_slot_rd;
  logic [CNT_W-1:0]      r_stall_cnt;

  // Per-slot comparison results.
  logic [DEPTH-1:0] w_rs_hit;
  logic [DEPTH-1:0] w_rt_hit;
  logic [DEPTH-1:0] w_hit;
  logic [DEPTH-1:0] w_first_hit;
  logic             w_found;
  logic             w_stall;
  logic             w_enter;

  // Compare both enabled sources against every checked, valid slot. The ID
  // instruction's own destination is not yet in any slot, so an instruction
  // that reads and writes the same register never hazards against itself.
  always_comb begin
    w_rs_hit = '0;
    w_rt_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_rs_hit[k] = CHECK_MASK[k] & r_slot_v[k] & i_id_rs_en &
                    (r_slot_rd[k] == i_id_rs);
      w_rt_hit[k] = CHECK_MASK[k] & r_slot_v[k] & i_id_rt_en &
                    (r_slot_rd[k] == i_id_rt);
    end
    w_hit = w_rs_hit | w_rt_hit;
  end

  // Lowest matching index is the youngest writer, which is the one that
  // determines how long the stall still has to last.
  always_comb begin
    w_first_hit = '0;
    w_found     = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_hit[k] && !w_found) begin
        w_first_hit[k] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  // Reset is folded in combinationally so that garbage left in the slots
  // cannot produce a stall while the pipeline is being reset. A squashed
  // instruction never needs its operands, so flush suppresses the stall.
  always_comb begin
    w_stall = ~i_rst & i_id_valid & ~i_flush & (|w_hit);
    w_enter = i_id_valid & i_id_wr_en & ~w_stall & ~i_flush;
  end

  assign o_stall       = w_stall;
  assign o_hazard_slot = w_stall ? w_first_hit : '0;
  assign o_stall_cnt   = r_stall_cnt;

  // The downstream stages never stall, so the slot pipeline advances every
  // cycle. A stalled instruction is re-presented by the upstream hold and
  // only enters slot 0 in its first non-stalled cycle; until then a bubble
  // (valid=0, rd=0) is shifted in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot_v  <= '0;
      r_slot_rd <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_slot_v[k]  <= r_slot_v[k-1];
        r_slot_rd[k] <= r_slot_rd[k-1];
      end
      r_slot_v[0]  <= w_enter;
      r_slot_rd[0] <= w_enter ? i_id_rd : 3'd0;
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones
  // instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
